// File: rtl/mono_sr_pkg.sv
// Shared types and constants for the MONOPIX configuration shift-register driver.
// Chain lengths are exported for software and for the bench.
package mono_sr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CRST,
    ST_PRE,
    ST_SHIFT,
    ST_GAP,
    ST_LOAD,
    ST_FIN
  } state_t;

  localparam logic [1:0] LOAD_NONE = 2'b00;
  localparam logic [1:0] LOAD_DAC  = 2'b01;
  localparam logic [1:0] LOAD_PIX  = 2'b10;
  localparam logic [1:0] LOAD_BOTH = 2'b11;

  localparam int GLOBAL_SR_BITS = 197;
  // 18 double-columns x 2 columns x 129 rows
  localparam int PIXEL_SR_BITS  = 18 * 2 * 129;
  localparam int CHIP_SR_BITS   = GLOBAL_SR_BITS + PIXEL_SR_BITS;

  function automatic logic [15:0] clamp_size(input logic [15:0] size, input int max_bits);
    if (int'(size) > max_bits) return 16'(max_bits);
    return size;
  endfunction

endpackage

// File: rtl/mono_sr_bytemem.sv
// Byte RAM with a register-bus port and an FSM port, both with one-cycle read latency.
// The FSM read sees a same-cycle bus write so unsent bits pick up late edits.
module mono_sr_bytemem #(
  parameter int MEM_BYTES = 1024
) (
  input  logic                         clk,
  input  logic                         bus_we,
  input  logic [$clog2(MEM_BYTES)-1:0] bus_addr,
  input  logic [7:0]                   bus_wdata,
  output logic [7:0]                   bus_rdata,
  input  logic                         fsm_we,
  input  logic [$clog2(MEM_BYTES)-1:0] fsm_addr,
  input  logic [7:0]                   fsm_wdata,
  output logic [7:0]                   fsm_rdata
);

  logic [7:0] mem [MEM_BYTES];

  always_ff @(posedge clk) begin
    if (bus_we) mem[bus_addr] <= bus_wdata;
    if (fsm_we) mem[fsm_addr] <= fsm_wdata;
    bus_rdata <= mem[bus_addr];
    if (bus_we && (bus_addr == fsm_addr)) fsm_rdata <= bus_wdata;
    else                                  fsm_rdata <= mem[fsm_addr];
  end

endmodule

// File: rtl/mono_sr_driver.sv
// MONOPIX configuration SR transmitter: streams the TX image over CONF_CLK/SR_IN, then pulses LD_DAC/LD_PIX.
// Define MONO_SR_READBACK_EN to capture SR_OUT into the RX buffer; otherwise RDATA reads 8'h00.
module mono_sr_driver
  import mono_sr_pkg::*;
#(
  parameter int MEM_BYTES   = 1024,
  parameter int PRE_CYCLES  = 4,
  parameter int LOAD_CYCLES = 8,
  parameter int RST_CYCLES  = 4
) (
  input  logic                         SR_CLK,
  input  logic                         RstInt,
  input  logic                         START,
  input  logic                         CHIP_RST_REQ,
  input  logic [15:0]                  SIZE,
  input  logic [1:0]                   LOAD_SEL,
  input  logic                         SR_EN_CFG,
  input  logic                         WR_EN,
  input  logic [$clog2(MEM_BYTES)-1:0] ADDR,
  input  logic [7:0]                   WDATA,
  output logic [7:0]                   RDATA,
  output logic                         BUSY,
  output logic                         DONE,
  output logic                         CONF_CLK,
  output logic                         SR_IN,
  output logic                         LD_DAC,
  output logic                         LD_PIX,
  output logic                         CHIP_SR_EN,
  output logic                         CHIP_SR_RST,
  input  logic                         SR_OUT
);

  localparam int          AW        = $clog2(MEM_BYTES);
  localparam int          MAX_BITS  = 8 * MEM_BYTES;
  localparam logic [15:0] PRE_LAST  = 16'(PRE_CYCLES - 1);
  localparam logic [15:0] LOAD_LAST = 16'(LOAD_CYCLES - 1);
  localparam logic [15:0] RST_LAST  = 16'(RST_CYCLES - 1);

  state_t      state;
  logic [15:0] cnt;
  logic [15:0] bit_cnt;
  logic        ph;
  logic        busy, done, conf_clk, sr_in, ld_dac, ld_pix, chip_sr_en, chip_sr_rst;

  logic [15:0] size_q;
  logic [1:0]  load_q;

  logic [15:0]   nxt_bit;
  logic [2:0]    nxt_pos;
  logic          last_bit;
  logic [AW-1:0] tx_addr;
  logic [7:0]    tx_q;
  logic [7:0]    unused_tx_rdata;

  assign nxt_bit  = bit_cnt + 16'd1;
  assign nxt_pos  = 3'd7 - nxt_bit[2:0];
  assign last_bit = (bit_cnt == size_q - 16'd1);
  // While shifting, fetch the byte of the following bit so it is ready at the next phase L.
  assign tx_addr  = (state == ST_SHIFT) ? nxt_bit[AW+2:3] : bit_cnt[AW+2:3];

  mono_sr_bytemem #(.MEM_BYTES(MEM_BYTES)) u_tx (
    .clk       (SR_CLK),
    .bus_we    (WR_EN),
    .bus_addr  (ADDR),
    .bus_wdata (WDATA),
    .bus_rdata (unused_tx_rdata),
    .fsm_we    (1'b0),
    .fsm_addr  (tx_addr),
    .fsm_wdata (8'h00),
    .fsm_rdata (tx_q)
  );

  always_ff @(posedge SR_CLK) begin
    if (state == ST_IDLE && START) begin
      size_q <= clamp_size(SIZE, MAX_BITS);
      load_q <= LOAD_SEL;
    end
  end

  always_ff @(posedge SR_CLK or posedge RstInt) begin
    if (RstInt) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      bit_cnt     <= '0;
      ph          <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      conf_clk    <= 1'b0;
      sr_in       <= 1'b0;
      ld_dac      <= 1'b0;
      ld_pix      <= 1'b0;
      chip_sr_en  <= 1'b0;
      chip_sr_rst <= 1'b0;
    end else begin
      done       <= 1'b0;
      chip_sr_en <= SR_EN_CFG;
      case (state)
        ST_IDLE: begin
          busy <= 1'b0;
          if (CHIP_RST_REQ) begin
            state       <= ST_CRST;
            cnt         <= RST_LAST;
            chip_sr_rst <= 1'b1;
            busy        <= 1'b1;
          end else if (START) begin
            state <= ST_PRE;
            cnt   <= PRE_LAST;
            busy  <= 1'b1;
          end
        end
        ST_CRST: begin
          if (cnt == 16'd0) begin
            chip_sr_rst <= 1'b0;
            done        <= 1'b1;
            state       <= ST_FIN;
          end else cnt <= cnt - 16'd1;
        end
        ST_PRE: begin
          if (cnt == 16'd0) begin
            if (size_q == 16'd0) begin
              state <= ST_GAP;
              cnt   <= 16'd1;
            end else begin
              state <= ST_SHIFT;
              ph    <= 1'b0;
              sr_in <= tx_q[7];
            end
          end else cnt <= cnt - 16'd1;
        end
        ST_SHIFT: begin
          if (!ph) begin
            conf_clk <= 1'b1;
            ph       <= 1'b1;
          end else begin
            conf_clk <= 1'b0;
            ph       <= 1'b0;
            if (last_bit) begin
              state   <= ST_GAP;
              cnt     <= 16'd1;
              sr_in   <= 1'b0;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= nxt_bit;
              sr_in   <= tx_q[nxt_pos];
            end
          end
        end
        ST_GAP: begin
          if (cnt == 16'd0) begin
            if (load_q == LOAD_NONE) begin
              done  <= 1'b1;
              state <= ST_FIN;
            end else begin
              ld_dac <= (load_q == LOAD_DAC) || (load_q == LOAD_BOTH);
              ld_pix <= (load_q == LOAD_PIX) || (load_q == LOAD_BOTH);
              cnt    <= LOAD_LAST;
              state  <= ST_LOAD;
            end
          end else cnt <= cnt - 16'd1;
        end
        ST_LOAD: begin
          if (cnt == 16'd0) begin
            ld_dac <= 1'b0;
            ld_pix <= 1'b0;
            done   <= 1'b1;
            state  <= ST_FIN;
          end else cnt <= cnt - 16'd1;
        end
        ST_FIN: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef MONO_SR_READBACK_EN
  // SR_OUT is sampled on the edge that raises CONF_CLK; bytes are committed one cycle later.
  logic          cap;
  logic [2:0]    rx_pos;
  logic [7:0]    rx_acc, rx_byte, rx_wdata;
  logic [AW-1:0] rx_waddr;
  logic          rx_we;
  logic [7:0]    unused_rx_rdata;

  assign cap    = (state == ST_SHIFT) && !ph;
  assign rx_pos = 3'd7 - bit_cnt[2:0];

  always_comb begin
    rx_byte         = rx_acc;
    rx_byte[rx_pos] = SR_OUT;
  end

  always_ff @(posedge SR_CLK or posedge RstInt) begin
    if (RstInt) rx_we <= 1'b0;
    else        rx_we <= cap && ((bit_cnt[2:0] == 3'd7) || last_bit);
  end

  always_ff @(posedge SR_CLK) begin
    if (state == ST_IDLE) begin
      rx_acc <= 8'h00;
    end else if (cap) begin
      rx_acc   <= (bit_cnt[2:0] == 3'd7) ? 8'h00 : rx_byte;
      rx_wdata <= rx_byte;
      rx_waddr <= bit_cnt[AW+2:3];
    end
  end

  mono_sr_bytemem #(.MEM_BYTES(MEM_BYTES)) u_rx (
    .clk       (SR_CLK),
    .bus_we    (1'b0),
    .bus_addr  (ADDR),
    .bus_wdata (8'h00),
    .bus_rdata (RDATA),
    .fsm_we    (rx_we),
    .fsm_addr  (rx_waddr),
    .fsm_wdata (rx_wdata),
    .fsm_rdata (unused_rx_rdata)
  );
`else
  logic unused_sr_out;
  assign unused_sr_out = SR_OUT;
  assign RDATA         = 8'h00;
`endif

  assign BUSY        = busy;
  assign DONE        = done;
  assign CONF_CLK    = conf_clk;
  assign SR_IN       = sr_in;
  assign LD_DAC      = ld_dac;
  assign LD_PIX      = ld_pix;
  assign CHIP_SR_EN  = chip_sr_en;
  assign CHIP_SR_RST = chip_sr_rst;

endmodule

// File: tb/tb_mono_sr_driver.sv
// Bench for mono_sr_driver: a byte-image model plus a 197-bit behavioural chip chain on CONF_CLK/SR_IN.
// RX readback is checked when MONO_SR_READBACK_EN is defined, otherwise RDATA must read zero.
module tb_mono_sr_driver;
  import mono_sr_pkg::*;

  localparam int MEM_BYTES = 1024;
  localparam int AW        = 10;
  localparam int PRE       = 4;
  localparam int LOADC     = 8;
  localparam int RSTC      = 4;

  logic          clk = 1'b0;
  logic          rst, start, crst_req, sr_en_cfg, wr_en;
  logic [15:0]   size;
  logic [1:0]    load_sel;
  logic [AW-1:0] addr;
  logic [7:0]    wdata, rdata;
  logic          busy, done, conf_clk, sr_in, ld_dac, ld_pix, chip_sr_en, chip_sr_rst, sr_out;

  always #5 clk = ~clk;

  mono_sr_driver #(
    .MEM_BYTES(MEM_BYTES), .PRE_CYCLES(PRE), .LOAD_CYCLES(LOADC), .RST_CYCLES(RSTC)
  ) dut (
    .SR_CLK(clk), .RstInt(rst), .START(start), .CHIP_RST_REQ(crst_req), .SIZE(size),
    .LOAD_SEL(load_sel), .SR_EN_CFG(sr_en_cfg), .WR_EN(wr_en), .ADDR(addr), .WDATA(wdata),
    .RDATA(rdata), .BUSY(busy), .DONE(done), .CONF_CLK(conf_clk), .SR_IN(sr_in),
    .LD_DAC(ld_dac), .LD_PIX(ld_pix), .CHIP_SR_EN(chip_sr_en), .CHIP_SR_RST(chip_sr_rst),
    .SR_OUT(sr_out)
  );

  // Behavioural global chain: shifts on CONF_CLK rise, last stage drives SR_OUT.
  logic [GLOBAL_SR_BITS-1:0] chip_sr = '0;
  always @(posedge conf_clk) chip_sr <= {chip_sr[GLOBAL_SR_BITS-2:0], sr_in};
  assign sr_out = chip_sr[GLOBAL_SR_BITS-1];

  logic [7:0] img [MEM_BYTES];
  int n_checks = 0;
  int n_errors = 0;

  logic obs_bits[$];
  int   obs_dac, obs_pix, obs_rst, obs_done, obs_busy_low;
  logic [1:0] obs_after;

  function automatic logic exp_bit(input int i);
    logic [7:0] b;
    b = img[i / 8];
    return b[7 - (i % 8)];
  endfunction

  function automatic int exp_done(input int n, input logic [1:0] sel);
    int m;
    m = (n > 8 * MEM_BYTES) ? 8 * MEM_BYTES : n;
    return 1 + PRE + ((m > 0) ? 2 * m : 0) + 2 + ((sel != 2'b00) ? LOADC : 0) + 1;
  endfunction

  function automatic int bit_errs(input int n);
    int e;
    e = 0;
    for (int i = 0; i < n && i < obs_bits.size(); i++)
      if (obs_bits[i] !== exp_bit(i)) e++;
    return e;
  endfunction

  task automatic write_byte(input int a, input logic [7:0] d);
    addr = AW'(a); wdata = d; wr_en = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0;
    img[a] = d;
  endtask

  task automatic fill_random(input int nbytes);
    for (int a = 0; a < nbytes; a++) write_byte(a, 8'($urandom));
  endtask

  // Drives one request and records what the pins do, cycle 1 being the request cycle.
  task automatic run_op(input int n, input logic [1:0] sel, input logic rq_rst,
                        input logic rq_start, input int max_cyc);
    logic prev;
    obs_bits.delete();
    obs_dac = 0; obs_pix = 0; obs_rst = 0; obs_done = 0; obs_busy_low = 0;
    prev = conf_clk;
    size = 16'(n); load_sel = sel; start = rq_start; crst_req = rq_rst;
    for (int c = 2; c <= max_cyc; c++) begin
      @(posedge clk); #1;
      start = 1'b0; crst_req = 1'b0;
      if (conf_clk && !prev) obs_bits.push_back(sr_in);
      prev = conf_clk;
      if (ld_dac) obs_dac++;
      if (ld_pix) obs_pix++;
      if (chip_sr_rst) obs_rst++;
      if (!busy) obs_busy_low++;
      if (done) begin obs_done = c; break; end
    end
    @(posedge clk); #1;
    obs_after = {done, busy};
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; crst_req = 1'b0; sr_en_cfg = 1'b1; wr_en = 1'b0;
    size = '0; load_sel = '0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, conf_clk, sr_in, ld_dac, ld_pix, chip_sr_rst, chip_sr_en} !== 8'h00) begin
      n_errors++;
      $display("FAIL reset_outputs: got %b want 00000000",
               {busy, done, conf_clk, sr_in, ld_dac, ld_pix, chip_sr_rst, chip_sr_en});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (chip_sr_en !== 1'b1) begin n_errors++; $display("FAIL sr_en_follow_hi: got %b want 1", chip_sr_en); end
    sr_en_cfg = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (chip_sr_en !== 1'b0) begin n_errors++; $display("FAIL sr_en_follow_lo: got %b want 0", chip_sr_en); end
    sr_en_cfg = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [15:0] want;
    int e;
    want = 16'b1010_0101_0011_1100;
    write_byte(0, 8'hA5);
    write_byte(1, 8'h3C);
    run_op(16, 2'b01, 1'b0, 1'b1, 200);
    n_checks++;
    if (obs_bits.size() != 16) begin n_errors++; $display("FAIL basic_edges: got %0d want 16", obs_bits.size()); end
    e = 0;
    for (int i = 0; i < 16 && i < obs_bits.size(); i++) if (obs_bits[i] !== want[15 - i]) e++;
    n_checks++;
    if (e != 0) begin n_errors++; $display("FAIL basic_bits: got %0d wrong bits want 0", e); end
    n_checks++;
    if (obs_dac != 8 || obs_pix != 0) begin
      n_errors++; $display("FAIL basic_strobes: got dac=%0d pix=%0d want dac=8 pix=0", obs_dac, obs_pix);
    end
    n_checks++;
    if (obs_done != 48) begin n_errors++; $display("FAIL basic_done_cycle: got %0d want 48", obs_done); end
    n_checks++;
    if (obs_busy_low != 0) begin n_errors++; $display("FAIL basic_busy: got %0d low cycles want 0", obs_busy_low); end
    n_checks++;
    if (obs_after !== 2'b00) begin n_errors++; $display("FAIL basic_after_done: got done/busy=%b want 00", obs_after); end
  endtask

  task automatic test_readback();
    int nb;
    logic [7:0] got, mask;
    nb = (GLOBAL_SR_BITS + 7) / 8;
`ifdef MONO_SR_READBACK_EN
    fill_random(nb);
    run_op(GLOBAL_SR_BITS, 2'b00, 1'b0, 1'b1, 1000);
    run_op(GLOBAL_SR_BITS, 2'b00, 1'b0, 1'b1, 1000);
    for (int a = 0; a < nb; a++) begin
      addr = AW'(a);
      @(posedge clk); #1;
      got  = rdata;
      mask = (a == nb - 1) ? 8'hF8 : 8'hFF;
      n_checks++;
      if ((got & mask) !== (img[a] & mask)) begin
        n_errors++; $display("FAIL readback_byte%0d: got %h want %h (mask %h)", a, got, img[a], mask);
      end
    end
`else
    for (int a = 0; a < 2; a++) begin
      addr = AW'(a * 5);
      @(posedge clk); #1;
      got  = rdata;
      mask = 8'h00;
      n_checks++;
      if (got !== mask) begin n_errors++; $display("FAIL rdata_tied_%0d: got %h want 00", a, got); end
    end
`endif
  endtask

  task automatic test_size_zero();
    run_op(0, 2'b10, 1'b0, 1'b1, 100);
    n_checks++;
    if (obs_bits.size() != 0) begin n_errors++; $display("FAIL zero_edges: got %0d want 0", obs_bits.size()); end
    n_checks++;
    if (obs_pix != 8 || obs_dac != 0) begin
      n_errors++; $display("FAIL zero_strobes: got pix=%0d dac=%0d want pix=8 dac=0", obs_pix, obs_dac);
    end
    n_checks++;
    if (obs_done != 16) begin n_errors++; $display("FAIL zero_done_cycle: got %0d want 16", obs_done); end
  endtask

  task automatic test_chip_reset_priority();
    int late_busy;
    run_op(16, 2'b01, 1'b1, 1'b1, 100);
    n_checks++;
    if (obs_rst != RSTC) begin n_errors++; $display("FAIL crst_width: got %0d want %0d", obs_rst, RSTC); end
    n_checks++;
    if (obs_bits.size() != 0 || obs_dac != 0) begin
      n_errors++; $display("FAIL crst_no_shift: got edges=%0d dac=%0d want 0 0", obs_bits.size(), obs_dac);
    end
    n_checks++;
    if (obs_done != 1 + RSTC + 1) begin n_errors++; $display("FAIL crst_done_cycle: got %0d want %0d", obs_done, 1 + RSTC + 1); end
    late_busy = 0;
    for (int c = 0; c < 10; c++) begin @(posedge clk); #1; if (busy || conf_clk) late_busy++; end
    n_checks++;
    if (late_busy != 0) begin n_errors++; $display("FAIL crst_start_dropped: got %0d active cycles want 0", late_busy); end
  endtask

  task automatic test_async_reset();
    int edges, late;
    logic prev;
    edges = 0; prev = 1'b0;
    size = 16'(CHIP_SR_BITS); load_sel = 2'b11; start = 1'b1;
    for (int c = 0; c < 2000 && edges < 100; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (conf_clk && !prev) edges++;
      prev = conf_clk;
    end
    n_checks++;
    if (edges != 100) begin n_errors++; $display("FAIL arst_reach_bit100: got %0d edges want 100", edges); end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, conf_clk, sr_in, ld_dac, ld_pix, chip_sr_rst, chip_sr_en} !== 8'h00) begin
      n_errors++;
      $display("FAIL arst_outputs: got %b want 00000000",
               {busy, done, conf_clk, sr_in, ld_dac, ld_pix, chip_sr_rst, chip_sr_en});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    late = 0; prev = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (done || busy || (conf_clk && !prev)) late++;
      prev = conf_clk;
    end
    n_checks++;
    if (late != 0) begin n_errors++; $display("FAIL arst_quiet: got %0d active cycles want 0", late); end
    fill_random(5);
    run_op(40, 2'b11, 1'b0, 1'b1, 300);
    n_checks++;
    if (obs_bits.size() != 40 || bit_errs(40) != 0) begin
      n_errors++; $display("FAIL arst_rerun_bits: got %0d edges %0d wrong want 40 0", obs_bits.size(), bit_errs(40));
    end
    n_checks++;
    if (obs_done != exp_done(40, 2'b11)) begin
      n_errors++; $display("FAIL arst_rerun_done: got %0d want %0d", obs_done, exp_done(40, 2'b11));
    end
  endtask

  task automatic test_clamp();
    fill_random(MEM_BYTES);
    run_op(9000, 2'b00, 1'b0, 1'b1, 20000);
    n_checks++;
    if (obs_bits.size() != 8 * MEM_BYTES) begin
      n_errors++; $display("FAIL clamp_edges: got %0d want %0d", obs_bits.size(), 8 * MEM_BYTES);
    end
    n_checks++;
    if (bit_errs(8 * MEM_BYTES) != 0) begin n_errors++; $display("FAIL clamp_bits: got %0d wrong want 0", bit_errs(8 * MEM_BYTES)); end
    n_checks++;
    if (obs_done != exp_done(9000, 2'b00)) begin
      n_errors++; $display("FAIL clamp_done: got %0d want %0d", obs_done, exp_done(9000, 2'b00));
    end
  endtask

  task automatic test_random();
    int n;
    logic [1:0] sel;
    for (int it = 0; it < 6; it++) begin
      n   = $urandom_range(1, 200);
      sel = 2'($urandom_range(0, 3));
      fill_random((n + 7) / 8);
      run_op(n, sel, 1'b0, 1'b1, 1000);
      n_checks++;
      if (obs_bits.size() != n || bit_errs(n) != 0) begin
        n_errors++; $display("FAIL rand%0d_bits: got %0d edges %0d wrong want %0d 0", it, obs_bits.size(), bit_errs(n), n);
      end
      n_checks++;
      if (obs_dac != (sel[0] ? LOADC : 0) || obs_pix != (sel[1] ? LOADC : 0)) begin
        n_errors++; $display("FAIL rand%0d_strobes: got dac=%0d pix=%0d sel=%b", it, obs_dac, obs_pix, sel);
      end
      n_checks++;
      if (obs_done != exp_done(n, sel)) begin
        n_errors++; $display("FAIL rand%0d_done: got %0d want %0d", it, obs_done, exp_done(n, sel));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_readback();
    test_size_zero();
    test_chip_reset_priority();
    test_async_reset();
    test_random();
    test_clamp();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mono_sr_driver.md
Name: mono_sr_driver

Overview:
- FPGA-side transmitter for the MONOPIX configuration shift-register interface.
- Streams a host-loaded bit image into the chip's global and pixel chains over Conf_Clk/SR_In, then issues the LdDAC or LdPix load strobe.
- Captures SR_out into a readback buffer so software can verify the chain.
- Sits between the DAQ register bus and the chip configuration pins.

Parameters:
- MEM_BYTES, 1024: depth of the TX and RX byte buffers; max image = 8*MEM_BYTES bits.
- PRE_CYCLES, 4: idle SR_CLK cycles between start accept and the first bit.
- LOAD_CYCLES, 8: width of the LD_DAC/LD_PIX pulse, in SR_CLK cycles.
- RST_CYCLES, 4: width of the CHIP_SR_RST pulse.

Ports:
- SR_CLK  in  1  clock for all logic; chip conf clock is derived from it.
- RstInt  in  1  reset, asynchronous, active-high.
- START  in  1  one-cycle shift request.
- CHIP_RST_REQ  in  1  one-cycle request for a chip SR reset pulse.
- SIZE  in  16  number of bits to shift; sampled at START.
- LOAD_SEL  in  2  sampled at START: 00 none, 01 LdDAC, 10 LdPix, 11 both.
- SR_EN_CFG  in  1  level forwarded to the chip SR_EN pin.
- WR_EN  in  1  TX buffer write strobe.
- ADDR  in  log2(MEM_BYTES)  byte address, shared by writes and reads.
- WDATA  in  8  TX buffer write data.
- RDATA  out  8  RX byte at ADDR; one-cycle read latency.
- BUSY  out  1  high from the cycle after an accepted request until return to IDLE.
- DONE  out  1  one-cycle pulse on return to IDLE.
- CONF_CLK  out  1  chip Clk_Conf.
- SR_IN  out  1  chip SR_In.
- LD_DAC  out  1  chip LdDAC.
- LD_PIX  out  1  chip LdPix.
- CHIP_SR_EN  out  1  chip SR_EN.
- CHIP_SR_RST  out  1  chip SR_RST.
- SR_OUT  in  1  chip SR_out; synchronous to CONF_CLK.

Behaviour:
- Reset values:
  - BUSY, DONE, CONF_CLK, SR_IN, LD_DAC, LD_PIX, CHIP_SR_RST, CHIP_SR_EN are all 0.
  - FSM enters IDLE; bit counter is 0.
  - Buffer contents are not reset.
- Every chip-side output is driven directly from a flop; no combinational path reaches a pin.
- FSM states: IDLE, CRST, PRE, SHIFT, GAP, LOAD, FIN.
- IDLE:
  - CHIP_RST_REQ goes to CRST; it has priority when it arrives in the same cycle as START.
  - START latches SIZE (clamped to 8*MEM_BYTES) and LOAD_SEL, then goes to PRE.
  - START or CHIP_RST_REQ outside IDLE is ignored; no queueing.
- CRST: CHIP_SR_RST high for RST_CYCLES, then FIN.
- PRE: PRE_CYCLES cycles, then SHIFT. If SIZE==0, go directly to GAP with no CONF_CLK edges.
- SHIFT: bit i occupies two cycles.
  - Phase L: CONF_CLK=0; SR_IN = bit i.
  - Phase H: CONF_CLK=1; SR_IN unchanged.
  - Bit i = TX byte i>>3, bit 7-(i&7), i.e. byte 0 first, MSB first.
  - Readback: SR_OUT is sampled on the SR_CLK edge that drives CONF_CLK 0->1 for bit i, and written to RX at the identical position as bit i.
  - After bit SIZE-1 phase H, go to GAP.
- GAP: 2 cycles with CONF_CLK=0; SR_IN returns to 0.
- LOAD:
  - Selected strobes are high together for LOAD_CYCLES, then FIN.
  - LOAD_SEL==00 skips LOAD and goes straight to FIN.
- FIN: DONE=1 for one cycle, then IDLE.
- CHIP_SR_EN = SR_EN_CFG, registered one cycle, in every state.
- Shift length: total cycles from START to DONE = 1 + PRE_CYCLES + 2*SIZE + 2 + LOAD_CYCLES(if selected) + 1.
- Bus access:
  - WR_EN is honoured in any state.
  - Writes to the byte currently being shifted take effect only for bits not yet sent.
  - A read returns RX content as of the previous cycle.
- Address wrap: the counter is 16 bits. SIZE above 8*MEM_BYTES is clamped, so the address never wraps.
- RstInt asserted mid-operation:
  - All strobes drop immediately (asynchronous reset); CONF_CLK goes to 0.
  - No DONE is produced.
  - The chip chain is left partially shifted.

Optional Feature:
- Macro MONO_SR_READBACK_EN.
- Defined: RX buffer and SR_OUT capture are present, as described above.
- Undefined:
  - RX buffer is removed; RDATA is tied to 8'h00.
  - SR_OUT is unused.
  - All other timing is identical.

Decomposition:
- Package mono_sr_pkg holds:
  - the state enum;
  - LOAD_SEL encodings;
  - GLOBAL_SR_BITS=197 and PIXEL_SR_BITS=4644 (18 double-columns x 2 x 129 rows);
  - a CHIP_SR_BITS constant equal to their sum, for software and bench.
- One sub-module, mono_sr_bytemem: a dual-port byte RAM with one bus port and one FSM port, instantiated once for TX and once for RX.

Test Plan:
- Write bytes 0xA5,0x3C; START with SIZE=16, LOAD_SEL=01. Required response:
  - SR_IN across the 16 CONF_CLK rising edges is 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0.
  - LD_DAC is high for exactly 8 cycles.
  - DONE arrives 1+4+32+2+8+1 = 48 cycles after START.
- Loop CONF_CLK/SR_IN through a 197-bit behavioural chip SR. Shift pattern P, then shift P again. Required response: RX bytes of the second pass equal P bit-exactly (MONO_SR_READBACK_EN defined).
- START with SIZE=0, LOAD_SEL=10. Required response: no CONF_CLK edge, LD_PIX high for 8 cycles, DONE arrives after 1+4+2+8+1 = 16 cycles.
- CHIP_RST_REQ and START in the same cycle. Required response: CHIP_SR_RST high for 4 cycles, DONE, no shifting; the START is dropped.
- Assert RstInt at bit 100 of a 4841-bit shift. Required response: all outputs are 0 in the same cycle, BUSY=0, no DONE; a following START runs a complete shift.
- START with SIZE=9000 and MEM_BYTES=1024. Required response: exactly 8192 CONF_CLK rising edges.
